uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Register-side bus of the UART receiver: read mux select, pop/clear strobes,
// read data and the level interrupt request toward the PLIC.
`timescale 1ns/1ps
interface uart_rx_fifo_if;
    logic        reg_sel;
    logic        pop;
    logic        clr_err;
    logic [31:0] rdata;
    logic        int_pending;

    // Bus decoder / CPU side
    modport master (
        output reg_sel,
        output pop,
        output clr_err,
        input  rdata,
        input  int_pending
    );

    // Receiver side
    modport slave (
        input  reg_sel,
        input  pop,
        input  clr_err,
        output rdata,
        output int_pending
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a byte FIFO, a data/status register pair and a
// level interrupt that stays high while received bytes are waiting.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_fifo_if.slave bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Register images: upper bits are always zero.
    function automatic logic [31:0] data_word(input logic [7:0] head_byte,
                                              input logic       valid);
        return {23'd0, valid, head_byte};
    endfunction

    function automatic logic [31:0] status_word(input logic [CW-1:0] cnt,
                                                input logic          ne,
                                                input logic          fl,
                                                input logic          ov,
                                                input logic          fe);
        logic [31:0] w;
        w       = '0;
        w[15:8] = 8'(cnt);
        w[3:0]  = {fe, ov, fl, ne};
        return w;
    endfunction

    logic          rx_meta;
    logic          rxs;
    logic          rxs_d;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          push;
    logic          frame_set;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          overrun_set;
    logic          overrun;
    logic          frame_err;
    logic          pending;
    logic [7:0]    head;

    // Two-stage synchroniser for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Receiver control state; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Data shift register needs no reset: it is only pushed after a full frame.
    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    // Frame sequencing: mid-bit sampling, LSB-first assembly, stop-bit validation.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        push         = 1'b0;
        frame_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (timer == TW'(HALF - 1)) begin
                    timer_next = '0;
                    if (!rxs) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        // Line went back high before mid start bit: treat as noise.
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == TW'(CLKS_PER_BIT - 1)) begin
                    timer_next   = '0;
                    shift_next   = {rxs, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            STOP: begin
                if (timer == TW'(CLKS_PER_BIT - 1)) begin
                    timer_next = '0;
                    state_next = IDLE;
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign do_pop      = bus.pop && !empty;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_push     = push && (!full || do_pop);
    assign overrun_set = push && full && !bus.pop;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // FIFO pointers, occupancy, sticky error flags and the registered interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_next;
            pending   <= (count_next != '0);
            // A new error in the same cycle as a clear keeps the flag set.
            overrun   <= overrun_set | (overrun & ~bus.clr_err);
            frame_err <= frame_set | (frame_err & ~bus.clr_err);
        end
    end

    // Byte storage; occupancy gating makes its reset state irrelevant.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift;
        end
    end

    assign head            = empty ? 8'h00 : mem[rd_ptr];
    assign bus.rdata       = bus.reg_sel ? status_word(count, !empty, full, overrun, frame_err)
                                         : data_word(head, !empty);
    assign bus.int_pending = pending;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus randomized frames.
// Expected register images and byte order come from a queue-based model;
// a negedge monitor owns all comparisons and the automatic draining pops.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB      = 16;
    localparam int DEPTH    = 4;
    // Edges from the first low sample of rx to the stop-bit decision:
    // two synchroniser stages, half a bit to mid start, nine full bits.
    localparam int PUSH_LAT = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        string       name;
        int          sel;    // 0 data reg, 1 status reg, 2 int_pending
        logic [31:0] exp;
    } chk_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rx      = 1'b1;
    logic reg_sel = 1'b0;
    logic man_pop = 1'b0;
    logic mon_pop = 1'b0;
    logic clr_err = 1'b0;
    logic mon_en  = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    chk_t       req_q[$];
    logic [7:0] data_q[$];
    bit         model_ferr;

    uart_rx_fifo_if bus();
    assign bus.reg_sel = reg_sel;
    assign bus.pop     = man_pop | mon_pop;
    assign bus.clr_err = clr_err;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: queued register checks first, otherwise drain pending bytes.
    always @(negedge clk) begin : monitor
        chk_t        r;
        logic [31:0] act;
        logic [7:0]  e;
        mon_pop = 1'b0;
        if (req_q.size() != 0) begin
            r = req_q.pop_front();
            reg_sel = (r.sel == 1);
            #1;
            act = (r.sel == 2) ? {31'd0, bus.int_pending} : bus.rdata;
            tests++;
            if (act !== r.exp) begin
                fails++;
                $display("FAIL %s: got 0x%08h, required 0x%08h", r.name, act, r.exp);
            end
        end else if (mon_en && bus.int_pending) begin
            reg_sel = 1'b0;
            #1;
            tests++;
            if (data_q.size() == 0) begin
                fails++;
                $display("FAIL rx_byte: got 0x%08h, required no pending byte", bus.rdata);
            end else begin
                e = data_q.pop_front();
                if (bus.rdata !== {23'd0, 1'b1, e}) begin
                    fails++;
                    $display("FAIL rx_byte: got 0x%08h, required 0x%08h", bus.rdata, {23'd0, 1'b1, e});
                end
            end
            mon_pop = 1'b1;
        end
    end

    task automatic expect_reg(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        req_q.push_back(c);
    endtask

    // Let the monitor consume every queued check; returns on a negedge.
    task automatic settle();
        int n = 0;
        while (req_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL settle: %0d checks still queued, required 0", req_q.size());
                $fatal(1, "monitor stalled");
            end
        end
        @(negedge clk);
    endtask

    // Wait (bounded) until the monitor has popped every expected byte.
    task automatic drain(input string name);
        int n = 0;
        while ((data_q.size() != 0 || bus.int_pending) && n < 400) begin
            @(negedge clk);
            n++;
        end
        expect_reg(name, 2, 32'd0);
        settle();
    endtask

    // One 8N1 frame, starting on a negedge; a bad stop bit is followed by one idle bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        if (!stop_ok) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_pop();
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         c0;
        logic [7:0] b;
        bit         ok;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_reg("reset_data", 0, 32'h0);
        expect_reg("reset_status", 1, 32'h0);
        expect_reg("reset_irq", 2, 32'h0);
        settle();

        // 1: single frame, manual pop
        send_frame(8'hA5, 1'b1);
        expect_reg("t1_irq", 2, 32'h1);
        expect_reg("t1_data", 0, 32'h000001A5);
        expect_reg("t1_status", 1, 32'h00000101);
        settle();
        pulse_pop();
        expect_reg("t1_data_after_pop", 0, 32'h0);
        expect_reg("t1_irq_after_pop", 2, 32'h0);
        settle();

        // 2: five back-to-back frames overflow a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        expect_reg("t2_status_full", 1, 32'h00000407);
        settle();
        for (int i = 1; i <= 4; i++) data_q.push_back(8'(i));
        mon_en = 1'b1;
        drain("t2_drained");
        mon_en = 1'b0;
        expect_reg("t2_status_after_pops", 1, 32'h00000004);
        settle();
        pulse_clr();
        expect_reg("t2_status_cleared", 1, 32'h0);
        settle();

        // 3: start-bit glitch, then a pop on an empty FIFO, then a good frame
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expect_reg("t3_glitch_status", 1, 32'h0);
        expect_reg("t3_glitch_irq", 2, 32'h0);
        settle();
        pulse_pop();
        expect_reg("t3_empty_pop_status", 1, 32'h0);
        settle();
        data_q.push_back(8'h3C);
        mon_en = 1'b1;
        send_frame(8'h3C, 1'b1);
        drain("t3_drained");
        mon_en = 1'b0;

        // 4: framing error is sticky until cleared
        send_frame(8'h7E, 1'b0);
        expect_reg("t4_status_ferr", 1, 32'h00000008);
        expect_reg("t4_irq", 2, 32'h0);
        settle();
        pulse_clr();
        expect_reg("t4_status_cleared", 1, 32'h0);
        settle();

        // 5: pop coincides with a push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        expect_reg("t5_status_full", 1, 32'h00000403);
        settle();
        c0 = cyc;
        fork
            send_frame(8'h99, 1'b1);
            begin
                while (cyc != c0 + PUSH_LAT) @(negedge clk);
                man_pop = 1'b1;
                @(negedge clk);
                man_pop = 1'b0;
            end
        join
        expect_reg("t5_status_after_race", 1, 32'h00000403);
        settle();
        data_q.push_back(8'h12);
        data_q.push_back(8'h13);
        data_q.push_back(8'h14);
        data_q.push_back(8'h99);
        mon_en = 1'b1;
        drain("t5_drained");
        mon_en = 1'b0;

        // 6: reset in the middle of the data bits
        send_frame(8'h55, 1'b1);
        expect_reg("t6_irq_before", 2, 32'h1);
        settle();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_reg("t6_status_after_rst", 1, 32'h0);
        expect_reg("t6_data_after_rst", 0, 32'h0);
        expect_reg("t6_irq_after_rst", 2, 32'h0);
        settle();
        repeat (2 * CPB) @(negedge clk);
        data_q.push_back(8'h42);
        mon_en = 1'b1;
        send_frame(8'h42, 1'b1);
        drain("t6_drained");
        mon_en = 1'b0;

        // Randomized frames with occasional bad stop bits, auto-drained
        model_ferr = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            if (ok) data_q.push_back(b);
            else    model_ferr = 1'b1;
            send_frame(b, ok);
            repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
        end
        drain("rand_drained");
        mon_en = 1'b0;
        expect_reg("rand_status", 1, model_ferr ? 32'h00000008 : 32'h0);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
